// File: rtl/parking_gate_sensor.sv
// Gate-lane beam decoder: synchronizes and debounces two beam sensors, then
// turns complete A->AB->B (entry) or B->AB->A (exit) passages into inc/dec pulses.
module parking_gate_sensor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic sensor_a,
  input  logic sensor_b,
  input  logic at_max,
  input  logic at_min,
  output logic inc,
  output logic dec,
  output logic fault
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, EN1, EN2, EN3, EX1, EX2, EX3, CLEAR
  } state_t;

  logic [1:0] r_s1, r_s2;
  logic [1:0] w_ab;  // {deb_a, deb_b}

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= {sensor_a, sensor_b};
      r_s2 <= r_s1;
    end
  end

  // Bit 1 is the street-side beam A, bit 0 the lot-side beam B.
  for (genvar i = 0; i < 2; i++) begin : g_deb
    logic          r_deb;
    logic [DW-1:0] r_cnt;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_deb <= 1'b0;
        r_cnt <= '0;
      end else if (r_s2[i] != r_deb) begin
        if (r_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
          r_deb <= r_s2[i];
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
    assign w_ab[i] = r_deb;
  end

  state_t        r_state, w_nxt;
  logic [TW-1:0] r_to;
  logic          w_inc_req, w_dec_req, w_flt, w_timed;

  assign w_timed = (r_state != IDLE) && (r_state != CLEAR);

  always_comb begin
    w_nxt     = r_state;
    w_inc_req = 1'b0;
    w_dec_req = 1'b0;
    w_flt     = 1'b0;
    case (r_state)
      IDLE: case (w_ab)
        2'b10:   w_nxt = EN1;
        2'b01:   w_nxt = EX1;
        2'b11:   w_nxt = CLEAR;
        default: ;
      endcase
      EN1: case (w_ab)
        2'b11:   w_nxt = EN2;
        2'b00:   w_nxt = IDLE;
        2'b01:   begin w_nxt = CLEAR; w_flt = 1'b1; end
        default: ;
      endcase
      EN2: case (w_ab)
        2'b01:   w_nxt = EN3;
        2'b10:   w_nxt = EN1;
        2'b00:   begin w_nxt = CLEAR; w_flt = 1'b1; end
        default: ;
      endcase
      EN3: case (w_ab)
        2'b00:   begin w_nxt = IDLE; w_inc_req = 1'b1; end
        2'b11:   w_nxt = EN2;
        2'b10:   begin w_nxt = CLEAR; w_flt = 1'b1; end
        default: ;
      endcase
      EX1: case (w_ab)
        2'b11:   w_nxt = EX2;
        2'b00:   w_nxt = IDLE;
        2'b10:   begin w_nxt = CLEAR; w_flt = 1'b1; end
        default: ;
      endcase
      EX2: case (w_ab)
        2'b10:   w_nxt = EX3;
        2'b01:   w_nxt = EX1;
        2'b00:   begin w_nxt = CLEAR; w_flt = 1'b1; end
        default: ;
      endcase
      EX3: case (w_ab)
        2'b00:   begin w_nxt = IDLE; w_dec_req = 1'b1; end
        2'b11:   w_nxt = EX2;
        2'b01:   begin w_nxt = CLEAR; w_flt = 1'b1; end
        default: ;
      endcase
      CLEAR: if (w_ab == 2'b00) w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
    // A stalled passage (no input change for TIMEOUT_CYCLES) is abandoned.
    if (w_timed && (w_nxt == r_state) && (r_to == TW'(TIMEOUT_CYCLES - 1))) begin
      w_nxt = CLEAR;
      w_flt = 1'b1;
    end
    w_flt = w_flt | (w_inc_req & at_max) | (w_dec_req & at_min);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_to    <= '0;
      inc     <= 1'b0;
      dec     <= 1'b0;
      fault   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      inc     <= w_inc_req & ~at_max;
      dec     <= w_dec_req & ~at_min;
      fault   <= w_flt;
      if (!w_timed || (w_nxt != r_state))
        r_to <= '0;
      else if (r_to != TW'(TIMEOUT_CYCLES - 1))
        r_to <= r_to + 1'b1;
    end
  end

endmodule

// File: tb/tb_parking_gate_sensor.sv
// Directed bench for parking_gate_sensor: passages, glitches, timeout,
// saturation guard and asynchronous reset, with hand-computed pulse timing.
module tb_parking_gate_sensor;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sensor_a = 1'b0, sensor_b = 1'b0, at_max = 1'b0, at_min = 1'b0;
  logic inc, dec, fault;

  int n_cmp = 0, n_bad = 0;
  int n_inc = 0, n_dec = 0, n_flt = 0;

  parking_gate_sensor #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(1000)) dut (
    .clk(clk), .reset(reset), .sensor_a(sensor_a), .sensor_b(sensor_b),
    .at_max(at_max), .at_min(at_min), .inc(inc), .dec(dec), .fault(fault)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (inc)   n_inc++;
    if (dec)   n_dec++;
    if (fault) n_flt++;
  end

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic entry_seq();
    sensor_a = 1'b1; step(20);
    sensor_b = 1'b1; step(20);
    sensor_a = 1'b0; step(20);
    sensor_b = 1'b0; step(20);
  endtask

  task automatic exit_seq();
    sensor_b = 1'b1; step(20);
    sensor_a = 1'b1; step(20);
    sensor_b = 1'b0; step(20);
    sensor_a = 1'b0; step(20);
  endtask

  task automatic test_reset();
    step(3);
    n_cmp++; if ({inc, dec, fault} !== 3'b000) begin n_bad++;
      $display("FAIL reset_hold: got %b want 000", {inc, dec, fault}); end
    reset = 1'b0;
    step(10);
    n_cmp++; if ({inc, dec, fault} !== 3'b000) begin n_bad++;
      $display("FAIL reset_release: got %b want 000", {inc, dec, fault}); end
  endtask

  task automatic test_entry();
    int i0, d0, f0;
    i0 = n_inc; d0 = n_dec; f0 = n_flt;
    sensor_a = 1'b1; step(20);
    sensor_b = 1'b1; step(20);
    sensor_a = 1'b0; step(20);
    sensor_b = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      n_cmp++; if (inc !== (k == 7)) begin n_bad++;
        $display("FAIL entry_latency cyc%0d: inc=%b want %b", k, inc, (k == 7)); end
    end
    step(5);
    n_cmp++; if (n_inc - i0 != 1) begin n_bad++;
      $display("FAIL entry_inc_count: got %0d want 1", n_inc - i0); end
    n_cmp++; if ((n_dec - d0) + (n_flt - f0) != 0) begin n_bad++;
      $display("FAIL entry_no_dec_fault: dec %0d fault %0d want 0 0", n_dec - d0, n_flt - f0); end
  endtask

  task automatic test_exit_reversal();
    int i0, d0, f0;
    i0 = n_inc; d0 = n_dec; f0 = n_flt;
    exit_seq();
    n_cmp++; if (n_dec - d0 != 1) begin n_bad++;
      $display("FAIL exit_dec_count: got %0d want 1", n_dec - d0); end
    d0 = n_dec;
    sensor_a = 1'b1; step(20);
    sensor_b = 1'b1; step(20);
    sensor_b = 1'b0; step(20);
    sensor_a = 1'b0; step(20);
    n_cmp++; if ((n_inc - i0) + (n_dec - d0) + (n_flt - f0) != 0) begin n_bad++;
      $display("FAIL reversal_pulses: inc %0d dec %0d fault %0d want 0 0 0",
               n_inc - i0, n_dec - d0, n_flt - f0); end
    entry_seq();
    n_cmp++; if (n_inc - i0 != 1) begin n_bad++;
      $display("FAIL reversal_back_idle: inc %0d want 1", n_inc - i0); end
  endtask

  task automatic test_glitch();
    int i0, d0, f0;
    i0 = n_inc; d0 = n_dec; f0 = n_flt;
    for (int k = 0; k < 20; k++) begin
      sensor_a = 1'b1; sensor_b = 1'b1; step(3);
      sensor_a = 1'b0; sensor_b = 1'b0; step(7);
    end
    step(10);
    n_cmp++; if ((n_inc - i0) + (n_dec - d0) + (n_flt - f0) != 0) begin n_bad++;
      $display("FAIL glitch_reject: inc %0d dec %0d fault %0d want 0 0 0",
               n_inc - i0, n_dec - d0, n_flt - f0); end
  endtask

  task automatic test_timeout();
    int i0, f0;
    i0 = n_inc; f0 = n_flt;
    // EN1 is entered on edge 7 after the raw edge; the fault lands 1000 later.
    sensor_a = 1'b1;
    for (int k = 1; k <= 1200; k++) begin
      step(1);
      if (k == 1006) begin
        n_cmp++; if (fault !== 1'b0) begin n_bad++;
          $display("FAIL timeout_early: fault=%b want 0", fault); end
      end
      if (k == 1007) begin
        n_cmp++; if (fault !== 1'b1) begin n_bad++;
          $display("FAIL timeout_edge: fault=%b want 1", fault); end
      end
    end
    n_cmp++; if (n_flt - f0 != 1) begin n_bad++;
      $display("FAIL timeout_once: faults %0d want 1", n_flt - f0); end
    sensor_a = 1'b0; step(20);
    n_cmp++; if ((n_inc - i0) != 0 || (n_flt - f0) != 1) begin n_bad++;
      $display("FAIL timeout_release: inc %0d fault %0d want 0 1", n_inc - i0, n_flt - f0); end
    entry_seq();
    n_cmp++; if (n_inc - i0 != 1) begin n_bad++;
      $display("FAIL timeout_recover: inc %0d want 1", n_inc - i0); end
  endtask

  task automatic test_saturation_illegal();
    int i0, f0;
    i0 = n_inc; f0 = n_flt;
    at_max = 1'b1;
    entry_seq();
    at_max = 1'b0;
    n_cmp++; if ((n_inc - i0) != 0 || (n_flt - f0) != 1) begin n_bad++;
      $display("FAIL sat_at_max: inc %0d fault %0d want 0 1", n_inc - i0, n_flt - f0); end
    i0 = n_inc; f0 = n_flt;
    sensor_a = 1'b1; step(20);
    sensor_b = 1'b1; step(20);
    sensor_a = 1'b0; sensor_b = 1'b0; step(20);
    n_cmp++; if ((n_inc - i0) != 0 || (n_flt - f0) != 1) begin n_bad++;
      $display("FAIL illegal_en2_00: inc %0d fault %0d want 0 1", n_inc - i0, n_flt - f0); end
    entry_seq();
    n_cmp++; if (n_inc - i0 != 1) begin n_bad++;
      $display("FAIL illegal_recover: inc %0d want 1", n_inc - i0); end
  endtask

  task automatic test_reset_mid();
    int i0, d0, f0;
    sensor_a = 1'b1; step(20);
    sensor_b = 1'b1; step(20);
    sensor_a = 1'b0; step(20);
    // FSM sits in EN3; b falls but reset arrives before it is debounced.
    sensor_b = 1'b0; step(3);
    #2 reset = 1'b1;
    #1;
    n_cmp++; if ({inc, dec, fault} !== 3'b000) begin n_bad++;
      $display("FAIL reset_async: got %b want 000", {inc, dec, fault}); end
    @(negedge clk);
    i0 = n_inc; d0 = n_dec; f0 = n_flt;
    step(3);
    reset = 1'b0;
    step(20);
    n_cmp++; if ((n_inc - i0) + (n_dec - d0) + (n_flt - f0) != 0) begin n_bad++;
      $display("FAIL reset_abandon: inc %0d dec %0d fault %0d want 0 0 0",
               n_inc - i0, n_dec - d0, n_flt - f0); end
    at_min = 1'b0;
    exit_seq();
    n_cmp++; if ((n_dec - d0) != 1 || (n_inc - i0) != 0) begin n_bad++;
      $display("FAIL reset_then_exit: dec %0d inc %0d want 1 0", n_dec - d0, n_inc - i0); end
  endtask

  initial begin
    test_reset();
    test_entry();
    test_exit_reversal();
    test_glitch();
    test_timeout();
    test_saturation_illegal();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/parking_gate_sensor.md
Name: parking_gate_sensor

Overview:
- Upstream stage of the parking-lot BCD occupancy counter.
- Watches two beam-break sensors across the gate lane, with A on the street side and B on the lot side.
- Decodes complete car passages and emits single-cycle inc (entry) and dec (exit) pulses that drive the counter's inc/dec inputs directly.
- Rejects glitches, partial passages, reversals and stuck sensors.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive cycles a synchronized sensor value must differ from the debounced value before it is accepted (1..255).
- TIMEOUT_CYCLES, 1000, maximum cycles allowed in any in-passage state without a debounced input change (2..2^20-1).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- sensor_a  input  1  street-side beam, 1 = blocked; asynchronous to clk.
- sensor_b  input  1  lot-side beam, 1 = blocked; asynchronous to clk.
- at_max  input  1  counter reads 99; suppresses inc.
- at_min  input  1  counter reads 00; suppresses dec.
- inc  output  1  one-cycle pulse: completed entry.
- dec  output  1  one-cycle pulse: completed exit.
- fault  output  1  one-cycle pulse: timeout, illegal sequence, or suppressed inc/dec.

Behaviour:
- Interface: one clock, clk. reset is asynchronous and active-high.
- Reset: async assert clears sync flops, debounced a/b, debounce and timeout counters, state=IDLE, inc=dec=fault=0. Outputs stay 0 throughout reset. Reset mid-passage abandons the passage with no pulse.
- Synchronizer: 2 flops per sensor.
- Debounce: one counter per sensor.
  - Counter increments while the sync value != debounced value; it clears when they are equal.
  - On reaching DEBOUNCE_CYCLES, debounced takes the sync value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never reaches the FSM.
- FSM input: ab = {deb_a, deb_b}, evaluated every cycle. Registered outputs.
- IDLE:
  - 10 -> EN1.
  - 01 -> EX1.
  - 11 -> CLEAR.
  - 00 -> stay.
- EN1 (10):
  - 11 -> EN2.
  - 00 -> IDLE (backed out, no pulse).
  - 01 -> CLEAR + fault.
- EN2 (11):
  - 01 -> EN3.
  - 10 -> EN1.
  - 00 -> CLEAR + fault.
- EN3 (01):
  - 00 -> IDLE + inc.
  - 11 -> EN2.
  - 10 -> CLEAR + fault.
- EX1/EX2/EX3: mirror of EN1/EN2/EN3 with a and b swapped. EX3 (10) -> 00 gives IDLE + dec.
- CLEAR: waits for 00, then -> IDLE. No pulses are issued from CLEAR.
- Timeout:
  - Counter clears on every state change and runs in all states except IDLE and CLEAR.
  - At TIMEOUT_CYCLES: -> CLEAR + fault.
- Saturation guard:
  - inc with at_max=1 is replaced by fault (inc stays 0).
  - dec with at_min=1 is replaced by fault (dec stays 0).
- inc and dec are never asserted together. Each pulse is exactly 1 cycle, registered.
- Latency: a raw edge held stable is seen by the FSM 2+DEBOUNCE_CYCLES cycles later. The resulting inc/dec/fault asserts on the next clk edge, 3+DEBOUNCE_CYCLES cycles after the raw edge in total.
- Counter widths are sized from the parameters; neither counter wraps. The timeout counter saturates until it is cleared.

Test Plan:
- Entry: defaults, a=1, +20 cycles b=1, +20 cycles a=0, +20 cycles b=0 -> single inc pulse 7 cycles after b falls; dec=fault=0 throughout.
- Exit plus reversal:
  - Full b,ab,a,00 sequence -> one dec.
  - Then a=1, ab, back to a, then 00 -> no pulse; FSM returns to IDLE.
- Glitch rejection: 3-cycle pulses on sensor_a and sensor_b every 10 cycles for 200 cycles -> inc=dec=fault=0.
- Timeout: a=1 held 1200 cycles -> fault pulse exactly once, 1000 cycles after FSM enters EN1. Releasing a -> IDLE with no pulse; a following full entry produces inc.
- Saturation and illegal jump:
  - Full entry with at_max=1 -> fault, no inc.
  - Entry path a -> 00 directly from EN2 -> fault, CLEAR, no inc.
- Reset mid-operation: assert reset asynchronously while in EN3 -> outputs 0 immediately. Release with sensors 00 -> no inc; a subsequent full exit with at_min=0 -> one dec.
